// File: rtl/i_img_pkg.sv
// Shared types and default widths for the image raster-scan blocks.
package i_img_pkg;

   localparam int DIM_W  = 13;
   localparam int ADDR_W = 24;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SCAN,
      DONE
   } scan_state_t;

endpackage

// File: rtl/i_pixel_scanner_if.sv
// Pixel stream from the raster scanner to the fetch/filter stage (valid/ready).
interface i_pixel_scanner_if
   import i_img_pkg::*;
#(
   parameter int DIM_W  = i_img_pkg::DIM_W,
   parameter int ADDR_W = i_img_pkg::ADDR_W
);

   logic              out_valid;
   logic              out_ready;
   logic [DIM_W-1:0]  col;
   logic [DIM_W-1:0]  row;
   logic [ADDR_W-1:0] pixel_addr;
   logic              last_col;
   logic              last_pixel;

   modport master (
      output out_valid, col, row, pixel_addr, last_col, last_pixel,
      input  out_ready
   );

   modport slave (
      input  out_valid, col, row, pixel_addr, last_col, last_pixel,
      output out_ready
   );

endinterface

// File: rtl/i_scan_counter.sv
// Wrapping index counter; at_terminal is registered so it lines up with value.
module i_scan_counter #(
   parameter int WIDTH = 13
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             clear,
   input  logic             count_enable,
   input  logic [WIDTH-1:0] terminal,
   output logic [WIDTH-1:0] value,
   output logic             at_terminal
);

   logic [WIDTH-1:0] value_q, value_d;
   logic             at_terminal_q, at_terminal_d;

   always_comb begin
      value_d = value_q;
      if (clear) begin
         value_d = '0;
      end else if (count_enable) begin
         value_d = at_terminal_q ? '0 : value_q + WIDTH'(1);
      end
      at_terminal_d = (value_d == terminal);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         value_q       <= '0;
         at_terminal_q <= 1'b0;
      end else begin
         value_q       <= value_d;
         at_terminal_q <= at_terminal_d;
      end
   end

   assign value       = value_q;
   assign at_terminal = at_terminal_q;

endmodule

// File: rtl/i_pixel_scanner.sv
// Raster-scan sequencer: walks a width x height frame row-major, emitting
// (row, col) and a linear address per pixel over a valid/ready stream.
module i_pixel_scanner
   import i_img_pkg::*;
#(
   parameter int DIM_W  = i_img_pkg::DIM_W,
   parameter int ADDR_W = i_img_pkg::ADDR_W
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic [DIM_W-1:0]     img_width,
   input  logic [DIM_W-1:0]     img_height,
   input  logic [ADDR_W-1:0]    base_addr,
   i_pixel_scanner_if.master    pix,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);

   scan_state_t       state_q, state_d;
   logic [DIM_W-1:0]  col_term_q, col_term_d;
   logic [DIM_W-1:0]  row_term_q, row_term_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              load;
   logic              accept;
   logic              col_en, row_en;
   logic              col_at, row_at;
   logic              last_col, last_pixel;
   logic [DIM_W-1:0]  col_val, row_val;

   assign accept     = out_valid_q && pix.out_ready;
   assign col_en     = accept && !abort;
   assign row_en     = col_en && col_at;
   assign last_col   = out_valid_q && col_at;
   assign last_pixel = last_col && row_at;

   // Terminals are muxed from the live inputs on the load edge so the
   // counters' registered at_terminal flags are correct from the first pixel.
   always_comb begin
      state_d     = state_q;
      col_term_d  = col_term_q;
      row_term_d  = row_term_q;
      addr_d      = addr_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      load        = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) begin
               if ((img_width != '0) && (img_height != '0)) begin
                  state_d    = LOAD;
                  load       = 1'b1;
                  col_term_d = img_width - DIM_W'(1);
                  row_term_d = img_height - DIM_W'(1);
                  addr_d     = base_addr;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         LOAD: begin
            state_d     = abort ? IDLE : SCAN;
            out_valid_d = !abort;
         end
         SCAN: begin
            if (abort) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end else if (accept) begin
               addr_d = addr_q + ADDR_W'(1);
               if (last_pixel) begin
                  state_d     = DONE;
                  out_valid_d = 1'b0;
                  done_d      = 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d == LOAD) || (state_d == SCAN);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q     <= IDLE;
         col_term_q  <= '0;
         row_term_q  <= '0;
         addr_q      <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_term_q  <= col_term_d;
         row_term_q  <= row_term_d;
         addr_q      <= addr_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   i_scan_counter #(.WIDTH(DIM_W)) u_col_counter (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (load),
      .count_enable (col_en),
      .terminal     (col_term_d),
      .value        (col_val),
      .at_terminal  (col_at)
   );

   i_scan_counter #(.WIDTH(DIM_W)) u_row_counter (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (load),
      .count_enable (row_en),
      .terminal     (row_term_d),
      .value        (row_val),
      .at_terminal  (row_at)
   );

   assign pix.out_valid  = out_valid_q;
   assign pix.col        = col_val;
   assign pix.row        = row_val;
   assign pix.pixel_addr = addr_q;
   assign pix.last_col   = last_col;
   assign pix.last_pixel = last_pixel;
   assign busy           = busy_q;
   assign done           = done_q;
   assign err            = err_q;

endmodule

// File: tb/tb_i_pixel_scanner.sv
// Directed bench for i_pixel_scanner with hand-derived raster expectations.
module tb_i_pixel_scanner;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        start;
   logic        abort;
   logic [12:0] img_width;
   logic [12:0] img_height;
   logic [23:0] base_addr;
   logic        busy;
   logic        done;
   logic        err;

   int assertCount = 0;
   int failCount   = 0;

   always #5 clk = ~clk;

   i_pixel_scanner_if pix ();

   i_pixel_scanner dut (
      .clk        (clk),
      .n_rst      (n_rst),
      .start      (start),
      .abort      (abort),
      .img_width  (img_width),
      .img_height (img_height),
      .base_addr  (base_addr),
      .pix        (pix),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Pulses start for one edge, then scrambles the dimension inputs.
   task automatic applyStimulus(input int w, input int h, input logic [23:0] base);
      img_width  = 13'(w);
      img_height = 13'(h);
      base_addr  = base;
      start      = 1'b1;
      tick();
      start      = 1'b0;
      img_width  = 13'h1FFF;
      img_height = 13'h1FFF;
      base_addr  = 24'hABCDEF;
   endtask

   task automatic checkIdle(input string tag);
      checkOutput({tag, "_valid"}, 32'(pix.out_valid), 32'd0);
      checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
      checkOutput({tag, "_done"}, 32'(done), 32'd0);
      checkOutput({tag, "_lastCol"}, 32'(pix.last_col), 32'd0);
      checkOutput({tag, "_lastPixel"}, 32'(pix.last_pixel), 32'd0);
   endtask

   task automatic runFrame(input int w, input int h, input logic [23:0] base,
                           input bit toggleReady, input bit pokeStart);
      int          k;
      int          cyc;
      logic        rdy;
      logic [23:0] eAddr;
      applyStimulus(w, h, base);
      checkOutput("loadBusy", 32'(busy), 32'd1);
      checkOutput("loadValid", 32'(pix.out_valid), 32'd0);
      tick();
      k   = 0;
      cyc = 0;
      while (k < w * h && cyc < 200) begin
         rdy           = toggleReady ? (cyc % 3 == 0) : 1'b1;
         pix.out_ready = rdy;
         start         = pokeStart && (cyc == 2);
         eAddr         = base + 24'(k);
         checkOutput("valid", 32'(pix.out_valid), 32'd1);
         checkOutput("row", 32'(pix.row), 32'(k / w));
         checkOutput("col", 32'(pix.col), 32'(k % w));
         checkOutput("addr", 32'(pix.pixel_addr), 32'(eAddr));
         checkOutput("lastCol", 32'(pix.last_col), 32'((k % w) == (w - 1)));
         checkOutput("lastPixel", 32'(pix.last_pixel), 32'(k == w * h - 1));
         checkOutput("scanBusy", 32'(busy), 32'd1);
         checkOutput("scanDone", 32'(done), 32'd0);
         tick();
         if (rdy) k++;
         cyc++;
      end
      start         = 1'b0;
      pix.out_ready = 1'b0;
      checkOutput("frameBeats", 32'(k), 32'(w * h));
      checkOutput("doneHigh", 32'(done), 32'd1);
      checkOutput("doneBusy", 32'(busy), 32'd0);
      checkOutput("doneValid", 32'(pix.out_valid), 32'd0);
      tick();
      checkOutput("doneLow", 32'(done), 32'd0);
   endtask

   initial begin
      n_rst         = 1'b0;
      start         = 1'b0;
      abort         = 1'b0;
      img_width     = '0;
      img_height    = '0;
      base_addr     = '0;
      pix.out_ready = 1'b0;
      tick();
      tick();
      checkIdle("reset");
      checkOutput("reset_err", 32'(err), 32'd0);
      checkOutput("reset_col", 32'(pix.col), 32'd0);
      checkOutput("reset_row", 32'(pix.row), 32'd0);
      checkOutput("reset_addr", 32'(pix.pixel_addr), 32'd0);
      n_rst = 1'b1;
      tick();

      $display("[TB] 3x2 frame, ready held high");
      runFrame(3, 2, 24'h000100, 1'b0, 1'b0);

      $display("[TB] 3x2 frame, ready toggling, start poked mid-scan");
      runFrame(3, 2, 24'h000100, 1'b1, 1'b1);

      $display("[TB] 1x1 frame");
      runFrame(1, 1, 24'h00ABCD, 1'b0, 1'b0);

      $display("[TB] address wrap");
      runFrame(4, 1, 24'hFFFFFE, 1'b0, 1'b0);

      $display("[TB] zero-dimension starts");
      applyStimulus(0, 2, 24'h0);
      checkOutput("errW0", 32'(err), 32'd1);
      checkOutput("errW0Busy", 32'(busy), 32'd0);
      checkOutput("errW0Valid", 32'(pix.out_valid), 32'd0);
      tick();
      checkOutput("errW0Low", 32'(err), 32'd0);
      applyStimulus(5, 0, 24'h0);
      checkOutput("errH0", 32'(err), 32'd1);
      checkOutput("errH0Busy", 32'(busy), 32'd0);
      tick();
      checkOutput("errH0Low", 32'(err), 32'd0);
      checkOutput("errH0Valid", 32'(pix.out_valid), 32'd0);

      $display("[TB] abort beats start in IDLE");
      abort = 1'b1;
      applyStimulus(2, 2, 24'h0);
      abort = 1'b0;
      checkOutput("idleAbortBusy", 32'(busy), 32'd0);
      checkOutput("idleAbortErr", 32'(err), 32'd0);
      tick();
      checkOutput("idleAbortValid", 32'(pix.out_valid), 32'd0);

      $display("[TB] abort on third accept of 4x4 frame");
      applyStimulus(4, 4, 24'h002000);
      tick();
      pix.out_ready = 1'b1;
      tick();
      tick();
      checkOutput("abortPreCol", 32'(pix.col), 32'd2);
      checkOutput("abortPreAddr", 32'(pix.pixel_addr), 32'h2002);
      abort = 1'b1;
      tick();
      abort         = 1'b0;
      pix.out_ready = 1'b0;
      checkIdle("abort");
      tick();
      checkOutput("abortNoDone", 32'(done), 32'd0);
      runFrame(4, 4, 24'h003000, 1'b0, 1'b0);

      $display("[TB] reset mid-scan of 8x4 frame");
      applyStimulus(8, 4, 24'h000500);
      tick();
      pix.out_ready = 1'b1;
      tick();
      tick();
      tick();
      checkOutput("midPreCol", 32'(pix.col), 32'd3);
      n_rst = 1'b0;
      tick();
      checkIdle("midReset");
      checkOutput("midReset_col", 32'(pix.col), 32'd0);
      checkOutput("midReset_row", 32'(pix.row), 32'd0);
      checkOutput("midReset_addr", 32'(pix.pixel_addr), 32'd0);
      n_rst         = 1'b1;
      pix.out_ready = 1'b0;
      tick();
      checkOutput("midResetNoDone", 32'(done), 32'd0);
      checkOutput("midResetValid", 32'(pix.out_valid), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule

// File: doc/i_pixel_scanner.md
# i_pixel_scanner

Raster-scan sequencer for image indexing: on a start pulse it walks every pixel of a `img_width` × `img_height` image in row-major order. For each pixel it emits the (row, col) index and a linear memory address. Pixels are handed to the downstream fetch/filter stage over a valid/ready handshake. It sits directly downstream of the image-dimension registers and upstream of the SRAM read port, and owns both the column and row counting for a frame.

## Interface
- `DIM_W`, 13: width of dimension, row and column values.
- `ADDR_W`, 24: width of base and pixel addresses.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `n_rst`  in  1  reset, synchronous, active-low.
- `start`  in  1  frame start request; honoured only in IDLE.
- `abort`  in  1  synchronous frame abort.
- `img_width`  in  DIM_W  pixels per row; sampled on accepted start.
- `img_height`  in  DIM_W  rows per frame; sampled on accepted start.
- `base_addr`  in  ADDR_W  address of pixel (0,0); sampled on accepted start.
- `out_ready`  in  1  downstream accepts the current pixel.
- `out_valid`  out  1  `col`/`row`/`pixel_addr` are valid.
- `col`  out  DIM_W  current column index.
- `row`  out  DIM_W  current row index.
- `pixel_addr`  out  ADDR_W  linear address of the current pixel.
- `last_col`  out  1  current pixel is the last in its row.
- `last_pixel`  out  1  current pixel is the last of the frame.
- `busy`  out  1  high in LOAD and SCAN.
- `done`  out  1  one-cycle pulse after the last pixel is accepted.
- `err`  out  1  one-cycle pulse when a start is rejected for a zero dimension.

## Operation
- States: IDLE, LOAD, SCAN, DONE. All outputs are registered.
- IDLE:
  - `start`=1 with both dimensions nonzero → LOAD. Latch `img_width`, `img_height` and `base_addr`; clear `col` and `row` to 0.
  - `start`=1 with either dimension 0 → stay in IDLE and pulse `err` for one cycle.
- LOAD → SCAN unconditionally. On entry to SCAN, `pixel_addr`=`base_addr` and `out_valid`=1.
- SCAN: an accept is `out_valid && out_ready`. On each accept:
  - If `col`==width−1: `col`→0 and `row`→row+1.
  - Otherwise `col`→col+1.
  - `pixel_addr`→pixel_addr+1, modulo 2^ADDR_W (wraps silently).
- Accept while `last_pixel`=1 → DONE. `out_valid` drops in the same edge.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- Without an accept, `col`, `row` and `pixel_addr` hold. `out_valid` never drops mid-frame.
- `last_col` = (col==width−1). `last_pixel` = `last_col` && (row==height−1). Both are valid only while `out_valid`=1 and are 0 otherwise.
- `abort`=1 in LOAD, SCAN or DONE → IDLE on the next edge. `out_valid`, `busy` and `done` clear on that edge, and no `done` pulse is issued. `abort` has priority over an accept in the same cycle. In IDLE, `abort` is ignored and has priority over `start` when both are high.
- `start` outside IDLE is ignored. Dimension inputs may change freely after they are latched.

## Timing
- Reset (`n_rst`=0 at an edge): state IDLE; `out_valid`, `busy`, `done`, `err`, `last_col` and `last_pixel` = 0; `col`, `row` and `pixel_addr` = 0. Reset mid-frame behaves the same way, with no `done` pulse.
- Start accepted at edge N: `busy`=1 after N. `out_valid`=1 after N+1 (first pixel, 2-cycle latency).
- With `out_ready` held at 1, one pixel is accepted per cycle. A W×H frame takes W·H cycles in SCAN. `done` is high in the cycle after the final accept, and `busy` falls on the same edge that `done` rises.
- A new `start` can be accepted in the cycle after `done` (back-to-back frames, 1 idle cycle).
- `err` is high for the one cycle following the rejected start edge.

## Structure
- Shared package `i_img_pkg`: `DIM_W` and `ADDR_W` defaults, and the `scan_state_t` enum (IDLE, LOAD, SCAN, DONE).
- One natural sub-module, `i_scan_counter`: a DIM_W-bit counter with `clear`, `count_enable`, a terminal value, and a `at_terminal` flag. Instantiate it twice:
  - Column: terminal = width−1, enabled on accept.
  - Row: terminal = height−1, enabled on accept && `last_col`.
- The FSM and address register live in the top module.

## Test plan
- Reset mid-SCAN of an 8×4 frame → next cycle: all outputs 0, state IDLE, no `done`.
- W=3, H=2, base=0x000100, `out_ready`=1 → (r,c,addr) sequence (0,0,0x100) through (1,2,0x105), one per cycle. `last_col` is high at c=2. `last_pixel` is high only at (1,2). `done` pulses once, 1 cycle after the final accept.
- Same frame with `out_ready` toggling 1,0,0,1… → identical sequence. Outputs hold on every ready=0 cycle, and `out_valid` never drops.
- W=1, H=1 → a single beat (0,0,base) with `last_col`=`last_pixel`=1, then `done`.
- `start` with W=0 or H=0 → `err` 1-cycle pulse, `busy` stays 0, `out_valid` stays 0. Also `start` during SCAN → ignored, sequence unchanged.
- base=0xFFFFFE, W=4, H=1 → addresses FFFFFE, FFFFFF, 000000, 000001. Also `abort` on the 3rd accept of a 4×4 frame → IDLE next edge, no `done`; a new start afterwards begins again at (0,0).
